taylor_horner_rtl: RTL and testbench
====================================

TAYLOR_HORNER_RTL -- requirements
Module: taylor_horner_rtl

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-high.
REQ-002 The block SHALL expose parameter WIDTH, default 24: bit width of angle_in, cos_out and internal datapath registers.
REQ-003 The block SHALL expose parameter FRAC, default 10: number of fractional bits (value = integer / 2^FRAC).
REQ-004 The block SHALL have port clock, input, 1 bit: rising-edge clock.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: request to begin a computation.
REQ-007 The block SHALL have port ready_out, output, 1 bit: result valid / block finished.
REQ-008 The block SHALL have port angle_in, input, WIDTH bits: signed two's-complement angle in radians, FRAC fractional bits.
REQ-009 The block SHALL have port cos_out, output, WIDTH bits: signed two's-complement cosine, FRAC fractional bits.
REQ-010 The port order SHALL be clock, reset, start, ready_out, angle_in, cos_out.

Function
REQ-011 The block SHALL compute cos(x) ≈ C0 + y*(C1 + y*(C2 + y*C3)) with y = x², using the Horner method.
REQ-012 Coefficients SHALL be round(±1/k! * 2^FRAC) for k = 0, 2, 4, 6; with FRAC=10: C0=1024, C1=-512, C2=43, C3=-1.
REQ-013 Every fixed-point multiply SHALL form the full 2*WIDTH-bit signed product, arithmetic-shift it right by FRAC (floor rounding), and truncate to WIDTH bits.
REQ-014 The specified input range SHALL be |x| <= 2.0 (|angle_in| <= 2048 at FRAC=10); overflow outside this range is unprotected and unspecified.
REQ-015 The FSM SHALL have the states IDLE, SQUARE, HORNER and DONE.
REQ-016 In IDLE, a rising clock edge with start=1 SHALL latch angle_in into x and move the FSM to SQUARE; with start=0 the FSM stays in IDLE.
REQ-017 In SQUARE, the block SHALL compute y = (x*x)>>>FRAC, set acc = C3, set index i = 2, and move to HORNER.
REQ-018 In HORNER, each clock edge SHALL compute acc = C[i] + ((acc*y)>>>FRAC) and decrement i.
REQ-019 The HORNER step for i=0 SHALL write its result to cos_out, set ready_out=1, and move to DONE, giving exactly 3 HORNER cycles.
REQ-020 Latency SHALL be fixed: when start is sampled at edge k, ready_out and cos_out are valid after edge k+4.
REQ-021 In DONE, ready_out SHALL stay 1 and cos_out SHALL stay stable.
REQ-022 The FSM SHALL leave DONE for IDLE at the first edge with start=0, clearing ready_out; holding start=1 SHALL NOT retrigger a computation.
REQ-023 cos_out SHALL keep the last result until the next computation completes; it SHALL NOT change during SQUARE or HORNER.
REQ-024 angle_in changes after the latching edge SHALL NOT affect the computation in progress.
REQ-025 start asserted in SQUARE or HORNER SHALL be ignored.
REQ-026 ready_out SHALL be 0 in IDLE, SQUARE and HORNER.

Reset
REQ-027 While reset=1, the FSM SHALL be in IDLE and ready_out, cos_out, x, y, acc and i SHALL all be 0, independent of the clock.
REQ-028 Reset asserted mid-computation SHALL abort it immediately.
REQ-029 After reset deasserts, the block SHALL accept a new start at the first rising edge.

Verification
REQ-030 angle_in=512 (0.5), start pulse -> after 4 cycles ready_out=1 and cos_out=898 (~0.877).
REQ-031 angle_in=0 -> cos_out=1024 (1.0).
REQ-032 angle_in=1024 (1.0) -> cos_out=554; angle_in=1536 (1.5) -> cos_out=74.
REQ-033 angle_in=-512 (0xFFFE00) -> cos_out=898, the same result as +0.5.
REQ-034 start held high for 5+ cycles -> exactly one computation and one ready_out rise; ready_out falls one edge after start drops.
REQ-035 Reset pulsed during HORNER -> ready_out=0 and cos_out=0 at once; a subsequent start with angle_in=512 gives 898.

Source files
------------

// File: rtl/taylor_horner_rtl.sv
// taylor_horner_rtl: fixed-point cos(x) via a 3-step Horner evaluation of the 6th-order Taylor series in y = x^2
//   clock     in  rising-edge clock
//   reset     in  asynchronous active-high reset
//   start     in  begin a computation (latched in IDLE only)
//   ready_out out result valid, held while in DONE
//   angle_in  in  signed angle in radians, FRAC fractional bits
//   cos_out   out signed cosine, FRAC fractional bits, holds the last result
module taylor_horner_rtl #(
    parameter int WIDTH = 24,
    parameter int FRAC  = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic             ready_out,
    input  logic [WIDTH-1:0] angle_in,
    output logic [WIDTH-1:0] cos_out
);
    typedef enum logic [1:0] {IDLE, SQUARE, HORNER, DONE} state_t;
    localparam logic signed [WIDTH-1:0] C0 = WIDTH'(2 ** FRAC);
    localparam logic signed [WIDTH-1:0] C1 = -WIDTH'(2 ** (FRAC - 1));
    localparam logic signed [WIDTH-1:0] C2 = WIDTH'((2 ** FRAC + 12) / 24);
    localparam logic signed [WIDTH-1:0] C3 = -WIDTH'((2 ** FRAC + 360) / 720);
    state_t state_q, state_d;
    logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d, acc_q, acc_d, cos_q, cos_d;
    logic [1:0] i_q, i_d;
    logic ready_q, ready_d;
    // full-width signed product, floor-shifted back to FRAC fractional bits
    function automatic logic signed [WIDTH-1:0] fmul(input logic signed [WIDTH-1:0] a, input logic signed [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] p;
        p = a * b;
        fmul = WIDTH'(p >>> FRAC);
    endfunction
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = acc_q;
        i_d     = i_q;
        cos_d   = cos_q;
        ready_d = ready_q;
        case (state_q)
            IDLE: if (start) begin
                x_d     = angle_in;
                state_d = SQUARE;
            end
            SQUARE: begin
                y_d     = fmul(x_q, x_q);
                acc_d   = C3;
                i_d     = 2'd2;
                state_d = HORNER;
            end
            HORNER: begin
                acc_d = (i_q == 2'd0 ? C0 : i_q == 2'd1 ? C1 : C2) + fmul(acc_q, y_q);
                i_d   = i_q - 2'd1;
                if (i_q == 2'd0) begin
                    cos_d   = acc_d;
                    ready_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: if (!start) begin
                ready_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            cos_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            cos_q   <= cos_d;
            ready_q <= ready_d;
        end
    end
    assign ready_out = ready_q;
    assign cos_out   = cos_q;
endmodule

// File: tb/tb_taylor_horner_rtl.sv
// tb_taylor_horner_rtl: table-driven and scoreboarded checks of taylor_horner_rtl
module tb_taylor_horner_rtl;
    logic        clock = 0;
    logic        reset = 1;
    logic        start = 0;
    logic        ready_out;
    logic [23:0] angle_in = '0;
    logic [23:0] cos_out;
    int checks = 0;
    int errors = 0;
    int q[$];
    int rises = 0;
    logic ready_prev = 0;
    typedef struct {int angle; int expect_cos;} vec_t;
    vec_t vecs[8];

    taylor_horner_rtl dut (
        .clock(clock), .reset(reset), .start(start),
        .ready_out(ready_out), .angle_in(angle_in), .cos_out(cos_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model(input int a);
        longint y, acc;
        y   = (longint'(a) * a) >>> 10;
        acc = -1;
        acc = 43 + ((acc * y) >>> 10);
        acc = -512 + ((acc * y) >>> 10);
        acc = 1024 + ((acc * y) >>> 10);
        return int'(acc);
    endfunction

    // scoreboard: pop the expected result on each rising ready_out
    always @(posedge clock) begin
        #1;
        if (ready_out && !ready_prev) begin
            rises++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %0d expected no result", int'($signed(cos_out)));
            end else
                check("sb_cos", int'($signed(cos_out)), q.pop_front());
        end
        ready_prev = ready_out;
    end

    task automatic run_vec(input int a, input int e);
        int prev;
        @(negedge clock);
        angle_in = 24'(a);
        start = 1;
        q.push_back(e);
        prev = int'($signed(cos_out));
        @(posedge clock); #1;
        angle_in = ~angle_in;
        check("ready_k0", int'(ready_out), 0);
        for (int j = 1; j <= 3; j++) begin
            @(posedge clock); #1;
            check("ready_busy", int'(ready_out), 0);
            check("cos_hold_busy", int'($signed(cos_out)), prev);
            if (j == 3) start = 0;
        end
        @(posedge clock); #1;
        check("ready_k4", int'(ready_out), 1);
        check("cos_k4", int'($signed(cos_out)), e);
        @(posedge clock); #1;
        check("ready_fall", int'(ready_out), 0);
        check("cos_keep", int'($signed(cos_out)), e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int r0;
        vecs[0] = '{512, 898};
        vecs[1] = '{0, 1024};
        vecs[2] = '{1024, 554};
        vecs[3] = '{1536, 74};
        vecs[4] = '{-512, 898};
        vecs[5] = '{-1024, 554};
        vecs[6] = '{2048, -400};
        vecs[7] = '{-2048, -400};
        #1;
        check("reset_ready", int'(ready_out), 0);
        check("reset_cos", int'($signed(cos_out)), 0);
        @(negedge clock);
        reset = 0;
        foreach (vecs[k]) run_vec(vecs[k].angle, vecs[k].expect_cos);
        for (int k = 0; k < 6; k++) begin
            int a;
            a = int'($urandom_range(4096)) - 2048;
            run_vec(a, model(a));
        end
        // start held high: one computation, ready stays up until start drops
        r0 = rises;
        @(negedge clock);
        angle_in = 24'(1024);
        start = 1;
        q.push_back(554);
        repeat (8) @(posedge clock);
        #1;
        check("hold_ready", int'(ready_out), 1);
        check("hold_cos", int'($signed(cos_out)), 554);
        @(negedge clock);
        start = 0;
        @(posedge clock); #1;
        check("hold_fall", int'(ready_out), 0);
        @(posedge clock); #1;
        check("hold_no_retrigger", int'(ready_out), 0);
        check("hold_rises", rises - r0, 1);
        // asynchronous reset in HORNER aborts the computation
        @(negedge clock);
        angle_in = 24'(1536);
        start = 1;
        q.push_back(74);
        repeat (3) @(posedge clock);
        @(negedge clock);
        start = 0;
        reset = 1;
        #1;
        check("abort_ready", int'(ready_out), 0);
        check("abort_cos", int'($signed(cos_out)), 0);
        q.delete();
        @(negedge clock);
        reset = 0;
        run_vec(512, 898);
        repeat (2) @(posedge clock);
        #2;
        check("sb_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
